// File: rtl/window_deser_pkg.sv
// Shared CNN datapath constants and helpers.
// Holds the pixel width and window size defaults used by the matrix generator,
// this deserializer and the MAC array, plus the window index width and the
// lane offset helper.
package window_deser_pkg;

    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned WIN_DEF = 9;
    localparam int unsigned IDX_W   = $clog2(WIN_DEF);

    // Bit offset of lane k inside a packed window word.
    function automatic int unsigned lane_off(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/win_out_reg.sv
// Output holding register for one parallel window, with valid/ready handshake
// and a wrapping count of delivered windows.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   load, load_data       capture a new window (sets valid)
//   ready                 downstream accepts data this cycle
//   data, valid           held window and its valid flag
//   cnt                   windows delivered (valid && ready), wraps
module win_out_reg #(
    parameter int unsigned W  = 72,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          ready,
    output logic [W-1:0]  data,
    output logic          valid,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deliver;

    always_comb begin
        deliver = valid_q && ready;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (deliver) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CW'(1);
        end
        // A load in the same cycle as a deliver keeps valid high with new data.
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/window_deser.sv
// Window deserializer: collects WIN serial pixels into one parallel word for
// the MAC stage. One collect buffer fills while the output register holds the
// previous window; a complete window waiting for the output freezes the input.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   sync_clr              drop the partial window and restart at element 0
//   in_data/valid/ready   serial pixel stream from the matrix generator
//   win_data/valid/ready  parallel window to the MAC (lane k at [k*DW +: DW])
//   win_cnt               windows delivered, wraps
module window_deser
    import window_deser_pkg::*;
#(
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned WIN = WIN_DEF,
    parameter int unsigned CW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync_clr,
    input  logic [DW-1:0]     in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIN*DW-1:0] win_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [CW-1:0]     win_cnt
);

    localparam int unsigned IW = (WIN > 1) ? $clog2(WIN) : 1;

    logic [IW-1:0]     idx_q, idx_d;
    logic              cfull_q, cfull_d;
    logic [WIN*DW-1:0] cbuf_q, cbuf_d;
    logic              accept, last, deliver, out_free, xfer;

    always_comb begin
        accept   = in_valid && !cfull_q && !sync_clr;
        last     = accept && (idx_q == IW'(WIN - 1));
        deliver  = win_valid && win_ready;
        out_free = !win_valid || deliver;
        xfer     = (last || cfull_q) && out_free && !sync_clr;

        // cbuf_d also serves as the transfer word, so the final element is folded in.
        cbuf_d = cbuf_q;
        if (accept) begin
            cbuf_d[lane_off(32'(idx_q), DW) +: DW] = in_data;
        end

        idx_d = idx_q;
        if (sync_clr) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = last ? '0 : idx_q + IW'(1);
        end

        cfull_d = cfull_q;
        if (sync_clr) begin
            cfull_d = 1'b0;
        end else if (cfull_q && out_free) begin
            cfull_d = 1'b0;
        end else if (last && !out_free) begin
            cfull_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            cfull_q <= 1'b0;
            cbuf_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            cfull_q <= cfull_d;
            cbuf_q  <= cbuf_d;
        end
    end

    // Registered only: never depends on in_valid.
    assign in_ready = !cfull_q;

    win_out_reg #(
        .W  (WIN * DW),
        .CW (CW)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (xfer),
        .load_data (cbuf_d),
        .ready     (win_ready),
        .data      (win_data),
        .valid     (win_valid),
        .cnt       (win_cnt)
    );

endmodule
